race_sequencer: RTL

RACE_SEQUENCER -- requirements
Module: race_sequencer

---
 rtl/race_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/race_sequencer.sv
// race_sequencer: start-lamp countdown, race timing and result latching
// for a single-player reaction/race game running on a 1 kHz clock.
//
// Optional feature: define BEST_TIME_EN to build the best-time register
// and its compare logic; otherwise best_sec/best_ms are tied to 0.
//
// Ports:
//   clk1KHz       1 kHz clock (1 cycle = 1 ms)
//   reset         synchronous, active-high
//   btn_go        start/rematch button (debounced level)
//   throttle      player throttle level
//   finish        finish-line crossing
//   seconds       external timer seconds
//   miliseconds   external timer milliseconds (0..999)
//   timer_start   timer count enable (RACE only)
//   timer_restart timer clear (ARM only)
//   lights        countdown lamps, bit0 lights first
//   go_light      green lamp
//   state         IDLE=0 ARM=1 COUNT=2 RACE=3 DONE=4 FOUL=5
//   result_valid  a finished race result is held
//   false_start   throttle during countdown
//   timeout       race aborted at 60 s
//   last_sec/ms   latched time of the last finished race
//   best_sec/ms   best finished race time
module race_sequencer (
   input  logic        clk1KHz,
   input  logic        reset,
   input  logic        btn_go,
   input  logic        throttle,
   input  logic        finish,
   input  logic [11:0] seconds,
   input  logic [9:0]  miliseconds,
   output logic        timer_start,
   output logic        timer_restart,
   output logic [2:0]  lights,
   output logic        go_light,
   output logic [2:0]  state,
   output logic        result_valid,
   output logic        false_start,
   output logic        timeout,
   output logic [11:0] last_sec,
   output logic [9:0]  last_ms,
   output logic [11:0] best_sec,
   output logic [9:0]  best_ms
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      COUNT = 3'd2,
      RACE  = 3'd3,
      DONE  = 3'd4,
      FOUL  = 3'd5
   } state_t;

   state_t      st;
   logic        btn_q;
   logic        go_edge;
   logic [9:0]  cnt;
   logic [1:0]  step;
   logic        cnt_wrap;

   assign go_edge  = btn_go & ~btn_q;
   assign cnt_wrap = (cnt == 10'd999);
   assign state    = st;

   always_ff @(posedge clk1KHz) begin
      if (reset) begin
         st            <= IDLE;
         // Sample the button during reset so a press held through
         // reset does not produce a start edge when reset drops.
         btn_q         <= btn_go;
         cnt           <= '0;
         step          <= '0;
         timer_start   <= 1'b0;
         timer_restart <= 1'b0;
         lights        <= 3'b000;
         go_light      <= 1'b0;
         result_valid  <= 1'b0;
         false_start   <= 1'b0;
         timeout       <= 1'b0;
         last_sec      <= '0;
         last_ms       <= '0;
      end else begin
         btn_q <= btn_go;
         unique case (st)
            IDLE, DONE, FOUL: begin
               if (go_edge) begin
                  st            <= ARM;
                  timer_restart <= 1'b1;
                  timer_start   <= 1'b0;
                  lights        <= 3'b000;
                  go_light      <= 1'b0;
                  cnt           <= '0;
                  step          <= '0;
                  result_valid  <= 1'b0;
                  false_start   <= 1'b0;
                  timeout       <= 1'b0;
               end
            end
            ARM: begin
               st            <= COUNT;
               timer_restart <= 1'b0;
               lights        <= 3'b001;
               cnt           <= '0;
               step          <= '0;
            end
            COUNT: begin
               // Throttle wins over the end-of-countdown move.
               if (throttle) begin
                  st          <= FOUL;
                  false_start <= 1'b1;
                  lights      <= 3'b000;
               end else if (cnt_wrap && step == 2'd2) begin
                  st          <= RACE;
                  lights      <= 3'b000;
                  go_light    <= 1'b1;
                  timer_start <= 1'b1;
               end else if (cnt_wrap) begin
                  cnt    <= '0;
                  step   <= step + 2'd1;
                  lights <= (step == 2'd0) ? 3'b011 : 3'b111;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            RACE: begin
               // Finish wins over a same-cycle timeout.
               if (finish) begin
                  st           <= DONE;
                  go_light     <= 1'b0;
                  timer_start  <= 1'b0;
                  result_valid <= 1'b1;
                  last_sec     <= seconds;
                  last_ms      <= miliseconds;
               end else if (seconds == 12'd60) begin
                  st          <= FOUL;
                  go_light    <= 1'b0;
                  timer_start <= 1'b0;
                  timeout     <= 1'b1;
                  false_start <= 1'b0;
               end
            end
            default: begin
               st <= IDLE;
            end
         endcase
      end
   end

`ifdef BEST_TIME_EN
   logic best_ok;
   logic better;

   // Seconds compared first; equal times keep the existing best.
   assign better = !best_ok
                 || (seconds < best_sec)
                 || (seconds == best_sec && miliseconds < best_ms);

   always_ff @(posedge clk1KHz) begin
      if (reset) begin
         best_ok  <= 1'b0;
         best_sec <= '0;
         best_ms  <= '0;
      end else if (st == RACE && finish && better) begin
         best_ok  <= 1'b1;
         best_sec <= seconds;
         best_ms  <= miliseconds;
      end
   end
`else
   assign best_sec = '0;
   assign best_ms  = '0;
`endif

endmodule
